wb_commit_queue: RTL and testbench
==================================

// Module: wb_commit_queue
// PURPOSE
//  Completion-side receiver for the FU issue path. Accepts finished results from the FP pipe
//  (FP_LATENCY deep) and the INT pipe, and buffers them in one in-order queue (WB_QUEUE_DEPTH).
//  Drains one entry per cycle into the register-file write port.
//  Frees the scoreboard/reservation entry (RsvID_t) in the same cycle its write is accepted.
// PARAMETERS
//  DEPTH   `WB_QUEUE_DEPTH (16)  queue entries; power of 2, >=2
//  PTR_W   $clog2(DEPTH)         pointer width (derived, not overridable)
// PORTS
//  clk             in   1       single clock; all state updates on posedge
//  rst             in   1       synchronous, active-high reset
//  fp_valid        in   1       FP result present
//  fp_ready        out  1       FP result accepted when fp_valid&fp_ready
//  fp_dst          in   11      GRegIdx_t destination register
//  fp_data         in   512     Vector_t result
//  fp_mask         in   16      Mask_t lane write-enables
//  fp_rsv          in   5       RsvID_t of producing instruction
//  int_valid/int_ready/int_dst/int_data/int_mask/int_rsv   same as fp_*, INT pipe
//  rf_wr_valid     out  1       head entry presented to register file
//  rf_wr_ready     in   1       register file accepts write this cycle
//  rf_wr_dst       out  11      head destination
//  rf_wr_data      out  512     head data
//  rf_wr_mask      out  16      head lane mask
//  rsv_free_valid  out  1       pulse: reservation released
//  rsv_free_id     out  5       released RsvID_t
//  q_count         out  PTR_W+1 occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0, storage contents don't-care.
//    Outputs after reset: rf_wr_valid=0, rsv_free_valid=0, q_count=0, rf_wr_dst/data/mask=0,
//    rsv_free_id=0; fp_ready=int_ready=1.
//    Reset mid-operation discards all entries; no rsv_free pulses are emitted for them.
//  - Readiness uses only registered count, never the same-cycle dequeue or the valids:
//      free = DEPTH-count; fp_ready = (free>=1); int_ready = (free>=2).
//    No combinational path from any valid to any ready.
//  - Enqueue: each accepted handshake writes one entry {dst,data,mask,rsv}.
//    If both are accepted in one cycle, the FP entry goes to wr_ptr and the INT entry to wr_ptr+1.
//    wr_ptr advances by 0/1/2 modulo DEPTH (natural PTR_W wrap).
//  - Output is show-ahead: rf_wr_valid = (count!=0).
//    rf_wr_dst/data/mask = head entry when valid, else forced 0.
//    Enqueue into an empty queue becomes visible the next cycle (1-cycle min latency); no bypass.
//  - Dequeue when rf_wr_valid&rf_wr_ready: rd_ptr+1 mod DEPTH.
//    Same cycle: rsv_free_valid=1, rsv_free_id=head rsv (combinational from the handshake).
//    Otherwise rsv_free_valid=0 and rsv_free_id=0.
//  - Head fields hold stable while rf_wr_valid=1 and rf_wr_ready=0.
//  - count_next = count + n_enq - n_deq; simultaneous enq/deq are legal at any occupancy,
//    including full (deq only) and empty (enq only). count never exceeds DEPTH.
//  - Order: entries leave strictly in enqueue order. No reordering by RsvID; no dst hazard checks
//    (the scoreboard owns those).
//  - Assertions: count<=DEPTH; never (fp_valid&fp_ready) when count==DEPTH;
//    never (int_valid&int_ready) when count>DEPTH-2.
// STRUCTURE
//  - gDefine package additions:
//      typedef struct packed {GRegIdx_t dst; Vector_t data; Mask_t mask; RsvID_t rsv;} WbEntry_t;
//      typedef logic [$clog2(`WB_QUEUE_DEPTH)-1:0] WbPtr_t;
//  - Sub-module wb_queue_mem: DEPTH x WbEntry_t register array, 2 write ports (w0 has priority
//    order, w1 at addr+1), 1 async read port; no reset on contents. Pointers, count and
//    handshake logic stay in wb_commit_queue.
// TESTING
//  1. Reset, idle: rf_wr_valid=0, q_count=0, fp_ready=int_ready=1, rsv_free_valid=0.
//  2. Single FP enq dst=5, rsv=3, mask=FFFF, rf_wr_ready=1 -> next cycle rf_wr_valid=1, dst=5;
//     same cycle rsv_free_valid=1, id=3; following cycle q_count=0.
//  3. Dual enq in one cycle (fp rsv=1, int rsv=2), rf_wr_ready=0 for 3 cycles, then 1
//     -> q_count=2; head fields stable while stalled; frees in order 1 then 2.
//  4. Fill with rf_wr_ready=0: int_ready drops at count=15, fp_ready drops at count=16.
//     FP enq at 15 accepted; 16 entries drain in enqueue order across pointer wrap.
//  5. Full queue, FP valid held, rf_wr_ready=1 for one cycle -> 1 dequeue; fp_ready=1 next
//     cycle; count returns to 16 after the enq.
//  6. Assert rst with 7 entries queued -> next cycle count=0, rf_wr_valid=0, no rsv_free pulses;
//     new enq after rst drains normally.

Source files
------------

// File: rtl/wb_commit_queue_pkg.sv
// Shared types for the write-back commit queue: register index, vector,
// lane mask, reservation id and the packed queue entry.
`ifndef WB_QUEUE_DEPTH
`define WB_QUEUE_DEPTH 16
`endif

package wb_commit_queue_pkg;

  localparam int WB_QUEUE_DEPTH = `WB_QUEUE_DEPTH;

  typedef logic [10:0]  GRegIdx_t;
  typedef logic [511:0] Vector_t;
  typedef logic [15:0]  Mask_t;
  typedef logic [4:0]   RsvID_t;

  // One buffered completion: where it goes, what it writes, which lanes,
  // and which reservation entry to release once the write is accepted.
  typedef struct packed {
    GRegIdx_t dst;
    Vector_t  data;
    Mask_t    mask;
    RsvID_t   rsv;
  } WbEntry_t;

  typedef logic [$clog2(`WB_QUEUE_DEPTH)-1:0] WbPtr_t;

endpackage

// File: rtl/wb_commit_queue_if.sv
// Bus bundle for the commit queue: FP and INT completion inputs, the
// register-file write port, the reservation-free pulse and the occupancy.
interface wb_commit_queue_if #(
  parameter int DEPTH = wb_commit_queue_pkg::WB_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) ();
  import wb_commit_queue_pkg::*;

  logic       fp_valid;
  logic       fp_ready;
  GRegIdx_t   fp_dst;
  Vector_t    fp_data;
  Mask_t      fp_mask;
  RsvID_t     fp_rsv;

  logic       int_valid;
  logic       int_ready;
  GRegIdx_t   int_dst;
  Vector_t    int_data;
  Mask_t      int_mask;
  RsvID_t     int_rsv;

  logic       rf_wr_valid;
  logic       rf_wr_ready;
  GRegIdx_t   rf_wr_dst;
  Vector_t    rf_wr_data;
  Mask_t      rf_wr_mask;

  logic       rsv_free_valid;
  RsvID_t     rsv_free_id;

  logic [PTR_W:0] q_count;

  // Queue side.
  modport slave (
    input  fp_valid, fp_dst, fp_data, fp_mask, fp_rsv,
    output fp_ready,
    input  int_valid, int_dst, int_data, int_mask, int_rsv,
    output int_ready,
    output rf_wr_valid, rf_wr_dst, rf_wr_data, rf_wr_mask,
    input  rf_wr_ready,
    output rsv_free_valid, rsv_free_id, q_count
  );

  // Pipes / register file side.
  modport master (
    output fp_valid, fp_dst, fp_data, fp_mask, fp_rsv,
    input  fp_ready,
    output int_valid, int_dst, int_data, int_mask, int_rsv,
    input  int_ready,
    input  rf_wr_valid, rf_wr_dst, rf_wr_data, rf_wr_mask,
    output rf_wr_ready,
    input  rsv_free_valid, rsv_free_id, q_count
  );

endinterface

// File: rtl/wb_queue_mem.sv
// Storage array for the commit queue: DEPTH entries, two write ports
// (port 1 always writes the slot after port 0) and one async read port.
module wb_queue_mem
  import wb_commit_queue_pkg::*;
#(
  parameter int DEPTH = WB_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_w0_en,
  input  logic [PTR_W-1:0] i_w0_addr,
  input  WbEntry_t         i_w0_data,
  input  logic             i_w1_en,
  input  WbEntry_t         i_w1_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output WbEntry_t         o_rd_data
);

  WbEntry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] w_w1_addr;

  // Natural wrap of the pointer width keeps addr+1 inside the array.
  assign w_w1_addr = i_w0_addr + PTR_W'(1);

  // Write both ports; their addresses always differ because DEPTH >= 2.
  // NOTE: the array has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed and the RAM stays cheap.
  always_ff @(posedge clk) begin
    if (i_w0_en) r_mem[i_w0_addr] <= i_w0_data;
    if (i_w1_en) r_mem[w_w1_addr] <= i_w1_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/wb_commit_queue.sv
// In-order write-back commit queue. Collects FP and INT completions, drains
// one entry per cycle into the register file and releases the producing
// reservation in the same cycle the write is accepted.
module wb_commit_queue
  import wb_commit_queue_pkg::*;
#(
  parameter int DEPTH = WB_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  wb_commit_queue_if.slave bus
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_DUAL = (PTR_W+1)'(DEPTH - 2);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_fp_acc;
  logic             w_int_acc;
  logic             w_valid;
  logic             w_deq;
  logic [PTR_W:0]   w_n_enq;
  logic [PTR_W:0]   w_n_deq;
  WbEntry_t         w_fp_entry;
  WbEntry_t         w_int_entry;
  WbEntry_t         w_w0_data;
  WbEntry_t         w_head;

  // Readiness looks only at registered occupancy so no valid feeds a ready.
  assign bus.fp_ready  = (r_count <  CNT_FULL);
  assign bus.int_ready = (r_count <= CNT_DUAL);

  assign w_fp_acc  = bus.fp_valid  & bus.fp_ready;
  assign w_int_acc = bus.int_valid & bus.int_ready;

  assign w_valid = (r_count != '0);
  assign w_deq   = w_valid & bus.rf_wr_ready;

  assign w_n_enq = (PTR_W+1)'(w_fp_acc) + (PTR_W+1)'(w_int_acc);
  assign w_n_deq = (PTR_W+1)'(w_deq);

  assign w_fp_entry  = '{dst: bus.fp_dst,  data: bus.fp_data,
                         mask: bus.fp_mask,  rsv: bus.fp_rsv};
  assign w_int_entry = '{dst: bus.int_dst, data: bus.int_data,
                         mask: bus.int_mask, rsv: bus.int_rsv};

  // Port 0 takes the first accepted entry (FP wins); port 1 only the INT
  // entry of a dual accept.
  // NOTE: every always_comb output gets a default before any condition so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_w0_data = w_int_entry;
    if (w_fp_acc) w_w0_data = w_fp_entry;
  end

  wb_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .i_w0_en   (w_fp_acc | w_int_acc),
    .i_w0_addr (r_wr_ptr),
    .i_w0_data (w_w0_data),
    .i_w1_en   (w_fp_acc & w_int_acc),
    .i_w1_data (w_int_entry),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  // Pointer and occupancy update; reset drops everything without frees.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_deq);
      r_count  <= r_count + w_n_enq - w_n_deq;
    end
  end

  // Show-ahead head; fields are zeroed whenever the queue is empty.
  assign bus.rf_wr_valid    = w_valid;
  assign bus.rf_wr_dst      = w_valid ? w_head.dst  : '0;
  assign bus.rf_wr_data     = w_valid ? w_head.data : '0;
  assign bus.rf_wr_mask     = w_valid ? w_head.mask : '0;
  assign bus.rsv_free_valid = w_deq;
  assign bus.rsv_free_id    = w_deq ? w_head.rsv : '0;
  assign bus.q_count        = r_count;

  // Occupancy and handshake sanity checks.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CNT_FULL);
      assert (!(w_fp_acc && r_count == CNT_FULL));
      assert (!(w_int_acc && r_count > CNT_DUAL));
    end
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: directed scenarios followed by
// random traffic, all compared each cycle against a FIFO reference model.
module tb_wb_commit_queue;
  import wb_commit_queue_pkg::*;

  localparam int DEPTH = WB_QUEUE_DEPTH;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  WbEntry_t model_q[$];

  always #5 clk = ~clk;

  wb_commit_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic WbEntry_t rand_entry();
    WbEntry_t e;
    e.dst = 11'($urandom);
    for (int i = 0; i < 16; i++) e.data[i*32 +: 32] = $urandom;
    e.mask = 16'($urandom);
    e.rsv  = 5'($urandom);
    return e;
  endfunction

  task automatic set_fp(input logic v, input WbEntry_t e);
    bus.fp_valid = v;
    bus.fp_dst   = e.dst;
    bus.fp_data  = e.data;
    bus.fp_mask  = e.mask;
    bus.fp_rsv   = e.rsv;
  endtask

  task automatic set_int(input logic v, input WbEntry_t e);
    bus.int_valid = v;
    bus.int_dst   = e.dst;
    bus.int_data  = e.data;
    bus.int_mask  = e.mask;
    bus.int_rsv   = e.rsv;
  endtask

  // Compare every output against the model, clock once, update the model.
  // Called with inputs already settled (>=1 time unit after the edge).
  task automatic step();
    int       sz;
    bit       fp_acc;
    bit       int_acc;
    bit       deq;
    WbEntry_t head;
    WbEntry_t fp_e;
    WbEntry_t int_e;
    sz   = model_q.size();
    head = (sz != 0) ? model_q[0] : '0;
    deq  = (sz != 0) && bus.rf_wr_ready;
    check("q_count",        bus.q_count,        sz);
    check("fp_ready",       bus.fp_ready,       sz <= DEPTH - 1);
    check("int_ready",      bus.int_ready,      sz <= DEPTH - 2);
    check("rf_wr_valid",    bus.rf_wr_valid,    sz != 0);
    check("rf_wr_dst",      bus.rf_wr_dst,      head.dst);
    check("rf_wr_data",     bus.rf_wr_data,     head.data);
    check("rf_wr_mask",     bus.rf_wr_mask,     head.mask);
    check("rsv_free_valid", bus.rsv_free_valid, deq);
    check("rsv_free_id",    bus.rsv_free_id,    deq ? head.rsv : 5'd0);
    fp_acc  = bus.fp_valid  && (sz <= DEPTH - 1);
    int_acc = bus.int_valid && (sz <= DEPTH - 2);
    fp_e    = '{dst: bus.fp_dst,  data: bus.fp_data,  mask: bus.fp_mask,  rsv: bus.fp_rsv};
    int_e   = '{dst: bus.int_dst, data: bus.int_data, mask: bus.int_mask, rsv: bus.int_rsv};
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (deq)     void'(model_q.pop_front());
      if (fp_acc)  model_q.push_back(fp_e);
      if (int_acc) model_q.push_back(int_e);
    end
    #1;
  endtask

  task automatic cyc();
    #1;
    step();
  endtask

  initial begin
    WbEntry_t e;
    WbEntry_t e2;
    int       rdy_pct;

    set_fp(1'b0, '0);
    set_int(1'b0, '0);
    bus.rf_wr_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();

    // 1. Idle after reset.
    cyc();
    cyc();

    // 2. Single FP enqueue drained immediately.
    e = rand_entry();
    e.dst = 11'd5; e.rsv = 5'd3; e.mask = 16'hFFFF;
    set_fp(1'b1, e);
    bus.rf_wr_ready = 1'b1;
    cyc();
    set_fp(1'b0, '0);
    #1;
    check("t2_valid",   bus.rf_wr_valid,    1'b1);
    check("t2_dst",     bus.rf_wr_dst,      11'd5);
    check("t2_free",    bus.rsv_free_valid, 1'b1);
    check("t2_free_id", bus.rsv_free_id,    5'd3);
    step();
    #1;
    check("t2_count", bus.q_count, 0);
    step();

    // 3. Dual enqueue, stall three cycles, then drain in FP-then-INT order.
    e  = rand_entry(); e.rsv  = 5'd1;
    e2 = rand_entry(); e2.rsv = 5'd2;
    set_fp(1'b1, e);
    set_int(1'b1, e2);
    bus.rf_wr_ready = 1'b0;
    cyc();
    set_fp(1'b0, '0);
    set_int(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_count",      bus.q_count,    2);
      check("t3_stable_dst", bus.rf_wr_dst,  e.dst);
      check("t3_stable_dat", bus.rf_wr_data, e.data);
      step();
    end
    bus.rf_wr_ready = 1'b1;
    #1;
    check("t3_free_id0", bus.rsv_free_id, 5'd1);
    step();
    #1;
    check("t3_free_id1", bus.rsv_free_id, 5'd2);
    step();
    bus.rf_wr_ready = 1'b0;
    cyc();

    // 4. Fill through INT until int_ready drops at 15, then top off with FP.
    for (int i = 0; i < 17; i++) begin
      set_int(1'b1, rand_entry());
      #1;
      if (model_q.size() == DEPTH - 1) begin
        check("t4_int_ready_15", bus.int_ready, 1'b0);
        check("t4_fp_ready_15",  bus.fp_ready,  1'b1);
      end
      step();
    end
    set_int(1'b0, '0);
    set_fp(1'b1, rand_entry());
    cyc();
    #1;
    check("t4_full_count", bus.q_count,  DEPTH);
    check("t4_fp_ready_16", bus.fp_ready, 1'b0);
    step();

    // 5. Full queue, FP held, one dequeue; the FP entry lands the next cycle.
    bus.rf_wr_ready = 1'b1;
    cyc();
    bus.rf_wr_ready = 1'b0;
    #1;
    check("t5_fp_ready", bus.fp_ready, 1'b1);
    step();
    set_fp(1'b0, '0);
    #1;
    check("t5_refill", bus.q_count, DEPTH);
    step();
    bus.rf_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cyc();

    // 6. Reset with seven entries queued; nothing is freed for them.
    bus.rf_wr_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_fp(1'b1, rand_entry());
      cyc();
    end
    set_fp(1'b0, '0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("t6_count", bus.q_count,        0);
    check("t6_valid", bus.rf_wr_valid,    1'b0);
    check("t6_free",  bus.rsv_free_valid, 1'b0);
    step();
    set_int(1'b1, rand_entry());
    cyc();
    set_int(1'b0, '0);
    bus.rf_wr_ready = 1'b1;
    cyc();
    cyc();

    // Random traffic at three drain rates, with occasional resets.
    for (int p = 0; p < 3; p++) begin
      case (p)
        0:       rdy_pct = 25;
        1:       rdy_pct = 60;
        default: rdy_pct = 90;
      endcase
      for (int c = 0; c < 250; c++) begin
        set_fp($urandom_range(0, 99) < 55, rand_entry());
        set_int($urandom_range(0, 99) < 55, rand_entry());
        rst = ($urandom_range(0, 199) == 0);
        bus.rf_wr_ready = !rst && ($urandom_range(0, 99) < rdy_pct);
        cyc();
      end
    end
    rst = 1'b0;
    set_fp(1'b0, '0);
    set_int(1'b0, '0);
    bus.rf_wr_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
